// File: rtl/bp_lce_stall_governor.sv
// LCE starvation governor: per-port starvation counters, a busy-hold window FSM,
// the outstanding-transaction credit counter and the final cache_req busy output.
module bp_lce_stall_governor #(
    parameter int unsigned num_ports_p         = 3,
    parameter int unsigned timeout_max_limit_p = 4,
    parameter int unsigned hold_cycles_p       = 2,
    parameter int unsigned credits_p           = 8,
    parameter int unsigned event_width_p       = 16,
    localparam int unsigned lg_limit_lp  = $clog2(timeout_max_limit_p + 1),
    localparam int unsigned lg_credit_lp = $clog2(credits_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [lg_limit_lp-1:0]   timeout_limit_i,
    input  logic [num_ports_p-1:0]   pkt_v_i,
    input  logic [num_ports_p-1:0]   pkt_yumi_i,
    input  logic                     credit_inc_i,
    input  logic                     credit_dec_i,
    input  logic                     cmd_ready_i,
    input  logic                     req_ready_i,
    output logic                     busy_o,
    output logic                     timeout_o,
    output logic [num_ports_p-1:0]   starved_o,
    output logic                     credits_full_o,
    output logic                     credits_empty_o,
    output logic [lg_credit_lp-1:0]  credit_count_o,
    output logic [event_width_p-1:0] timeout_events_o,
    output logic                     err_o
);

    localparam int unsigned hold_width_lp = (hold_cycles_p > 1) ? $clog2(hold_cycles_p) : 1;
    localparam logic [hold_width_lp-1:0] hold_load_lp = hold_width_lp'(hold_cycles_p - 1);
    localparam logic [lg_credit_lp-1:0]  credits_max_lp = lg_credit_lp'(credits_p);

    typedef enum logic [1:0] {e_idle, e_hold, e_drain} state_e;

    state_e                                 state_q, state_d;
    logic [hold_width_lp-1:0]               hold_q, hold_d;
    logic [num_ports_p-1:0][lg_limit_lp-1:0] cnt_q, cnt_d;
    logic [lg_credit_lp-1:0]                credit_q, credit_d;
    logic [event_width_p-1:0]               events_q, events_d;
    logic                                   err_q, err_d;
    logic [num_ports_p-1:0]                 blocked;
    logic                                   trigger;

    assign blocked = pkt_v_i & ~pkt_yumi_i;

    // >= rather than == so a limit lowered below a live count still flags starvation.
    always_comb begin
        cnt_d     = '0;
        starved_o = '0;
        for (int i = 0; i < num_ports_p; i++) begin
            starved_o[i] = (cnt_q[i] >= timeout_limit_i) && (timeout_limit_i != '0);
            if (blocked[i]) begin
                cnt_d[i] = (cnt_q[i] >= timeout_limit_i) ? timeout_limit_i
                                                         : cnt_q[i] + lg_limit_lp'(1);
            end
        end
    end

    assign trigger = |starved_o;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        events_d = events_q;
        unique case (state_q)
            e_idle: begin
                if (trigger) begin
                    state_d = e_hold;
                    hold_d  = hold_load_lp;
                    if (events_q != '1) events_d = events_q + event_width_p'(1);
                end
            end
            e_hold: begin
                if (hold_q == '0) begin
                    state_d = (|blocked) ? e_drain : e_idle;
                end else begin
                    hold_d = hold_q - hold_width_lp'(1);
                end
            end
            e_drain: begin
                if (blocked == '0) state_d = e_idle;
            end
            default: state_d = e_idle;
        endcase
    end

    assign credits_full_o  = (credit_q == credits_max_lp);
    assign credits_empty_o = (credit_q == '0);

    always_comb begin
        credit_d = credit_q;
        err_d    = err_q;
        if (credit_inc_i && !credit_dec_i) begin
            if (credits_full_o) err_d = 1'b1;
            else credit_d = credit_q + lg_credit_lp'(1);
        end else if (credit_dec_i && !credit_inc_i) begin
            if (credits_empty_o) err_d = 1'b1;
            else credit_d = credit_q - lg_credit_lp'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= e_idle;
            hold_q   <= '0;
            cnt_q    <= '0;
            credit_q <= '0;
            events_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            credit_q <= credit_d;
            events_q <= events_d;
            err_q    <= err_d;
        end
    end

    // Trigger feeds busy directly so the hold takes effect in the trigger cycle.
    assign timeout_o        = trigger || (state_q != e_idle);
    assign busy_o           = credits_full_o | timeout_o | ~cmd_ready_i | ~req_ready_i;
    assign credit_count_o   = credit_q;
    assign timeout_events_o = events_q;
    assign err_o            = err_q;

endmodule

// File: tb/tb_bp_lce_stall_governor.sv
// Bench for bp_lce_stall_governor: directed scenarios plus a randomized phase,
// all checked against a cycle-level behavioural model of the governor.
module tb_bp_lce_stall_governor;

    localparam int NP   = 3;
    localparam int HOLD = 2;
    localparam int CRED = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  limit;
    logic [NP-1:0] v, y;
    logic        inc, dec, cmd, req;
    logic        busy, timeout, full, empty, err;
    logic [NP-1:0] starved;
    logic [3:0]  count;
    logic [15:0] events;

    int total = 0;
    int bad   = 0;

    // Behavioural model state: consecutive blocked-cycle run lengths, remaining
    // window cycles, drain flag, event count, credits and error flag.
    int m_run [NP];
    int m_win;
    bit m_drain;
    int m_events;
    int m_cred;
    bit m_err;

    always #5 clk = ~clk;

    bp_lce_stall_governor dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .timeout_limit_i  (limit),
        .pkt_v_i          (v),
        .pkt_yumi_i       (y),
        .credit_inc_i     (inc),
        .credit_dec_i     (dec),
        .cmd_ready_i      (cmd),
        .req_ready_i      (req),
        .busy_o           (busy),
        .timeout_o        (timeout),
        .starved_o        (starved),
        .credits_full_o   (full),
        .credits_empty_o  (empty),
        .credit_count_o   (count),
        .timeout_events_o (events),
        .err_o            (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) m_run[i] = 0;
        m_win = 0; m_drain = 0; m_events = 0; m_cred = 0; m_err = 0;
    endtask

    function automatic logic [NP-1:0] m_starved();
        logic [NP-1:0] s = '0;
        for (int i = 0; i < NP; i++)
            s[i] = (limit != 0) && (m_run[i] >= int'(limit));
        return s;
    endfunction

    task automatic check_all();
        logic [NP-1:0] s;
        bit t, b;
        s = m_starved();
        t = (s != 0) || (m_win > 0) || m_drain;
        b = (m_cred == CRED) || t || !cmd || !req;
        chk("starved", 32'(starved), 32'(s));
        chk("timeout", 32'(timeout), 32'(t));
        chk("busy",    32'(busy),    32'(b));
        chk("count",   32'(count),   32'(m_cred));
        chk("full",    32'(full),    32'(m_cred == CRED));
        chk("empty",   32'(empty),   32'(m_cred == 0));
        chk("events",  32'(events),  32'(m_events));
        chk("err",     32'(err),     32'(m_err));
    endtask

    task automatic model_step();
        logic [NP-1:0] blk;
        bit trig;
        blk  = v & ~y;
        trig = (m_starved() != 0);
        if (m_win == 0 && !m_drain) begin
            if (trig) begin
                m_win = HOLD;
                if (m_events < 65535) m_events++;
            end
        end else if (m_win > 0) begin
            m_win--;
            if (m_win == 0) m_drain = (blk != 0);
        end else if (blk == 0) begin
            m_drain = 0;
        end
        for (int i = 0; i < NP; i++) begin
            if (!blk[i]) m_run[i] = 0;
            else m_run[i] = (m_run[i] + 1 < int'(limit)) ? m_run[i] + 1 : int'(limit);
        end
        if (inc && !dec) begin
            if (m_cred == CRED) m_err = 1; else m_cred++;
        end else if (dec && !inc) begin
            if (m_cred == 0) m_err = 1; else m_cred--;
        end
    endtask

    task automatic cyc();
        #1;
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic [NP-1:0] vv, input logic [NP-1:0] yy,
                         input logic ii, input logic dd);
        v = vv; y = yy; inc = ii; dec = dd;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #3;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        limit = 3'd4; v = '0; y = '0; inc = 0; dec = 0; cmd = 1; req = 1;
        model_reset();
        #12;
        chk("rst_empty",   32'(empty),   32'd1);
        chk("rst_full",    32'(full),    32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_starved", 32'(starved), 32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_err",     32'(err),     32'd0);
        reset_n = 1'b1;

        // Port 1 starves at limit 4, then is accepted; two-cycle hold then release.
        drive(3'b010, 3'b000, 0, 0);
        repeat (4) cyc();
        chk("s1_starved", 32'(starved), 32'b010);
        chk("s1_busy",    32'(busy),    32'd1);
        drive(3'b010, 3'b010, 0, 0);
        cyc();
        chk("s1_events", 32'(events), 32'd1);
        chk("s1_hold",   32'(timeout), 32'd1);
        repeat (2) cyc();
        chk("s1_release", 32'(busy), 32'd0);
        drive(3'b000, 3'b000, 0, 0);
        cyc();

        // Port 0 blocked three cycles then accepted: never reaches the limit.
        do_reset();
        for (int r = 0; r < 3; r++) begin
            drive(3'b001, 3'b000, 0, 0);
            repeat (3) cyc();
            drive(3'b001, 3'b001, 0, 0);
            cyc();
        end
        chk("s2_events", 32'(events), 32'd0);

        // Limit 2, port 2 blocked ten cycles: hold, then drain until accepted.
        limit = 3'd2;
        drive(3'b100, 3'b000, 0, 0);
        repeat (2) cyc();
        chk("s3_trig", 32'(timeout), 32'd1);
        repeat (8) cyc();
        chk("s3_drain", 32'(busy), 32'd1);
        drive(3'b100, 3'b100, 0, 0);
        cyc();
        chk("s3_done", 32'(busy), 32'd0);
        drive(3'b000, 3'b000, 0, 0);
        limit = 3'd4;

        // Credit saturation.
        do_reset();
        drive(3'b000, 3'b000, 1, 0);
        repeat (CRED) cyc();
        chk("c_full",  32'(full),  32'd1);
        chk("c_busy",  32'(busy),  32'd1);
        drive(3'b000, 3'b000, 1, 1);
        cyc();
        chk("c_both",  32'(count), 32'd8);
        chk("c_noerr", 32'(err),   32'd0);
        drive(3'b000, 3'b000, 1, 0);
        cyc();
        chk("c_over", 32'(err), 32'd1);

        // Reset in the middle of a hold with five credits outstanding.
        do_reset();
        drive(3'b000, 3'b000, 1, 0);
        repeat (5) cyc();
        drive(3'b010, 3'b000, 0, 0);
        repeat (5) cyc();
        chk("r_inhold", 32'(timeout), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("r_count",   32'(count),   32'd0);
        chk("r_empty",   32'(empty),   32'd1);
        chk("r_events",  32'(events),  32'd0);
        chk("r_err",     32'(err),     32'd0);
        chk("r_timeout", 32'(timeout), 32'd0);
        model_reset();
        reset_n = 1'b1;
        drive(3'b000, 3'b000, 0, 1);
        cyc();
        chk("c_under", 32'(err), 32'd1);

        // Limit 0 disables detection; busy tracks only the ready inputs.
        limit = 3'd0;
        drive(3'b111, 3'b000, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cmd = 1'($urandom_range(0, 1));
            req = 1'($urandom_range(0, 1));
            cyc();
        end
        cmd = 1; req = 1;

        // Randomized phase with occasional limit changes and a mid-run reset.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 30 == 0) limit = 3'($urandom_range(0, 4));
            if (i == 200) do_reset();
            v   = NP'($urandom);
            y   = NP'($urandom) & NP'($urandom);
            inc = ($urandom_range(0, 2) == 0);
            dec = ($urandom_range(0, 2) == 0);
            cmd = ($urandom_range(0, 7) != 0);
            req = ($urandom_range(0, 7) != 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
